uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 124 ++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a 2-flop input synchronizer and mid-bit sampling.
// Define UART_RX_PARITY_EN to add an even-parity bit (PARITY state) and the o_parity_err output.
module uart_rx #(
  parameter int CLKS_PER_BIT = 1250
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic       o_parity_err
`endif
);
  localparam logic [10:0] LP_FULL = 11'(CLKS_PER_BIT - 1);
  localparam logic [10:0] LP_HALF = 11'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_sync1;
  logic        r_rx_s;
  logic        r_armed;
  logic [10:0] r_cnt;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shift;
  logic        w_half;
  logic        w_full;
  logic        w_data_smp;
  logic        w_stop_smp;
  logic        w_par_bad;
  logic        w_load;
  logic        w_ferr;
`ifdef UART_RX_PARITY_EN
  logic        r_par;
`endif

  assign w_half = (r_cnt == LP_HALF);
  assign w_full = (r_cnt == LP_FULL);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (r_armed && !r_rx_s) w_next = S_START;
      S_START: if (w_half) w_next = r_rx_s ? S_IDLE : S_DATA;
`ifdef UART_RX_PARITY_EN
      S_DATA:   if (w_full && (r_bit_idx == 3'd7)) w_next = S_PARITY;
      S_PARITY: if (w_full) w_next = S_STOP;
`else
      S_DATA:  if (w_full && (r_bit_idx == 3'd7)) w_next = S_STOP;
`endif
      S_STOP:  if (w_full) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_data_smp = (r_state == S_DATA) && w_full;
    w_stop_smp = (r_state == S_STOP) && w_full;
`ifdef UART_RX_PARITY_EN
    w_par_bad  = w_stop_smp && (r_par != ^r_shift);
`else
    w_par_bad  = 1'b0;
`endif
    w_load     = w_stop_smp && r_rx_s && !w_par_bad;
    w_ferr     = w_stop_smp && !r_rx_s;
    o_busy     = (r_state != S_IDLE);
  end

  // Synchronizer idles high so reset never looks like a start bit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1      <= 1'b1;
      r_rx_s       <= 1'b1;
      r_armed      <= 1'b0;
      r_cnt        <= 11'd0;
      r_bit_idx    <= 3'd0;
      r_shift      <= 8'h00;
      o_data       <= 8'h00;
      o_valid      <= 1'b0;
      o_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par        <= 1'b0;
      o_parity_err <= 1'b0;
`endif
    end else begin
      r_sync1 <= i_rx;
      r_rx_s  <= r_sync1;
      if (w_ferr)                          r_armed <= 1'b0;
      else if ((r_state == S_IDLE) && r_rx_s) r_armed <= 1'b1;
      if ((w_next != r_state) || w_data_smp || (r_state == S_IDLE)) r_cnt <= 11'd0;
      else                                                        r_cnt <= r_cnt + 11'd1;
      if (w_data_smp) begin
        r_shift   <= {r_rx_s, r_shift[7:1]};
        r_bit_idx <= r_bit_idx + 3'd1;
      end
      o_valid     <= w_load;
      o_frame_err <= w_ferr;
      if (w_load) o_data <= r_shift;
`ifdef UART_RX_PARITY_EN
      if ((r_state == S_PARITY) && w_full) r_par <= r_rx_s;
      o_parity_err <= w_par_bad;
`endif
    end
  end

endmodule
